// File: rtl/decode_stage.sv
// RV32/RV64 decode pipeline stage: combinational decode captured into a
// 2-entry (main + skid) buffer with valid/ready on both sides and a flopped in_ready.
module decode_stage #(
    parameter int unsigned XLEN          = 32,
    parameter bit          ENABLE_M      = 1'b1,
    parameter bit          ENABLE_SYSTEM = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic [6:0]      out_op,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [2:0]      out_alu_op,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_instr_type,
    output logic            out_word,
    output logic            out_illegal
);

    localparam logic [2:0] T_U = 3'd1, T_J = 3'd2, T_B = 3'd3,
                           T_I = 3'd4, T_S = 3'd5, T_R = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [6:0]      op;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [2:0]      alu_op;
        logic [XLEN-1:0] imm;
        logic [2:0]      itype;
        logic            word;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

    logic [6:0]      opc;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic            shift_ok;
    logic            funct7_ok;
    logic            legal;
    logic            accept;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    entry_t          dec_entry;

    state_t          state_q;
    entry_t          main_q;
    entry_t          skid_q;
    logic            in_ready_q;
    logic            out_valid_q;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    // Shift immediates allow only the SRAI pattern in the bits above shamt.
    assign shift_ok = (XLEN == 32)
        ? ((f7 == 7'b0) || (f7 == 7'b0100000 && f3 == 3'b101))
        : ((in_instr[31:26] == 6'b0) || (in_instr[31:26] == 6'b010000 && f3 == 3'b101));

    assign funct7_ok = (f7 == 7'b0000000)
                    || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
                    || (f7 == 7'b0000001 && ENABLE_M);

    // Fill with the sign bit, then overlay the 32-bit immediate pattern.
    always_comb begin
        imm_i = {XLEN{in_instr[31]}};
        imm_s = {XLEN{in_instr[31]}};
        imm_b = {XLEN{in_instr[31]}};
        imm_j = {XLEN{in_instr[31]}};
        imm_u = {XLEN{in_instr[31]}};
        imm_i[11:0] = in_instr[31:20];
        imm_s[11:0] = {in_instr[31:25], in_instr[11:7]};
        imm_b[12:0] = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        imm_j[20:0] = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
        imm_u[31:0] = {in_instr[31:12], 12'h000};
    end

    always_comb begin
        dec_entry       = '0;
        dec_entry.pc    = in_pc;
        dec_entry.instr = in_instr;
        dec_entry.op    = opc;
        legal           = 1'b1;
        case (opc)
            7'b0110111, 7'b0010111: begin
                dec_entry.itype = T_U; dec_entry.rd = in_instr[11:7]; dec_entry.imm = imm_u;
            end
            7'b1101111: begin
                dec_entry.itype = T_J; dec_entry.rd = in_instr[11:7]; dec_entry.imm = imm_j;
            end
            7'b1100111: begin
                dec_entry.itype = T_I; dec_entry.rd = in_instr[11:7]; dec_entry.rs1 = in_instr[19:15];
                dec_entry.funct3 = f3; dec_entry.imm = imm_i;
                legal = (f3 == 3'b000);
            end
            7'b1100011: begin
                dec_entry.itype = T_B; dec_entry.rs1 = in_instr[19:15]; dec_entry.rs2 = in_instr[24:20];
                dec_entry.funct3 = f3; dec_entry.imm = imm_b;
                dec_entry.alu_op = (f3 == 3'b001) ? 3'b000 : f3;
                legal = (f3[2:1] != 2'b01);
            end
            7'b0000011: begin
                dec_entry.itype = T_I; dec_entry.rd = in_instr[11:7]; dec_entry.rs1 = in_instr[19:15];
                dec_entry.funct3 = f3; dec_entry.imm = imm_i;
                legal = (f3 != 3'b111) && !(XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110));
            end
            7'b0100011: begin
                dec_entry.itype = T_S; dec_entry.rs1 = in_instr[19:15]; dec_entry.rs2 = in_instr[24:20];
                dec_entry.funct3 = f3; dec_entry.imm = imm_s;
                legal = !f3[2] && !(XLEN == 32 && f3 == 3'b011);
            end
            7'b0010011, 7'b0011011: begin
                dec_entry.itype = T_I; dec_entry.rd = in_instr[11:7]; dec_entry.rs1 = in_instr[19:15];
                dec_entry.funct3 = f3; dec_entry.alu_op = f3; dec_entry.imm = imm_i;
                if (opc == 7'b0011011) begin
                    dec_entry.word = 1'b1;
                    legal = (XLEN == 64);
                end else if (f3 == 3'b001 || f3 == 3'b101) begin
                    legal = shift_ok;
                end
            end
            7'b0110011, 7'b0111011: begin
                dec_entry.itype = T_R; dec_entry.rd = in_instr[11:7]; dec_entry.rs1 = in_instr[19:15];
                dec_entry.rs2 = in_instr[24:20]; dec_entry.funct3 = f3; dec_entry.funct7 = f7;
                dec_entry.alu_op = f3;
                dec_entry.word = (opc == 7'b0111011);
                legal = funct7_ok && (opc == 7'b0110011 || XLEN == 64);
            end
            7'b0001111, 7'b1110011: begin
                dec_entry.itype = T_I; dec_entry.rd = in_instr[11:7]; dec_entry.rs1 = in_instr[19:15];
                dec_entry.funct3 = f3; dec_entry.alu_op = f3; dec_entry.imm = imm_i;
                legal = ENABLE_SYSTEM;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec_entry         = '0;
            dec_entry.pc      = in_pc;
            dec_entry.instr   = in_instr;
            dec_entry.op      = opc;
            dec_entry.illegal = 1'b1;
        end
    end

    assign accept = in_valid && in_ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: if (accept) begin
                    main_q      <= dec_entry;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_FULL;
                end
                ST_FULL: begin
                    if (accept && out_ready) begin
                        main_q <= dec_entry;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end else if (accept) begin
                        skid_q     <= dec_entry;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_SKID;
                    end
                end
                ST_SKID: if (out_ready) begin
                    main_q     <= skid_q;
                    in_ready_q <= 1'b1;
                    state_q    <= ST_FULL;
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = out_valid_q;
    assign out_pc         = main_q.pc;
    assign out_instr      = main_q.instr;
    assign out_op         = main_q.op;
    assign out_rd         = main_q.rd;
    assign out_rs1        = main_q.rs1;
    assign out_rs2        = main_q.rs2;
    assign out_funct3     = main_q.funct3;
    assign out_funct7     = main_q.funct7;
    assign out_alu_op     = main_q.alu_op;
    assign out_imm        = main_q.imm;
    assign out_instr_type = main_q.itype;
    assign out_word       = main_q.word;
    assign out_illegal    = main_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32/RV64 instruction decode pipeline stage with valid/ready handshakes on both sides and a 2-entry skid buffer, so a registered in_ready still gives full throughput.
- Sits between fetch and execute and replaces the combinational decoder plus the memory-based stall logic. Backpressure is carried by out_ready instead.
- Adds illegal-instruction detection on funct fields, optional M and SYSTEM/FENCE decode, RV64 word ops, and a synchronous flush.

Parameters:
- XLEN, 32, data/PC width. Legal values are 32 or 64; imm is sign-extended to XLEN.
- ENABLE_M, 1, R-type/OP-32 funct7=0000001 is legal (type 110) when 1, illegal when 0.
- ENABLE_SYSTEM, 1, opcodes 0001111 and 1110011 decode as I-type when 1, illegal when 0.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; discards all held entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept; driven directly from a flop
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded entry available
- out_ready  in  1  execute accepts the entry
- out_pc  out  XLEN  PC of the entry
- out_instr  out  32  raw instruction
- out_op  out  7  instr[6:0]
- out_rd, out_rs1, out_rs2  out  5 each  register indices; 0 when unused
- out_funct3  out  3  funct3; 0 when unused
- out_funct7  out  7  funct7; 0 when unused
- out_alu_op  out  3  ALU operation
- out_imm  out  XLEN  sign-extended immediate
- out_instr_type  out  3  000 none/illegal, 001 U, 010 J, 011 B, 100 I, 101 S, 110 R
- out_word  out  1  RV64 *W op (opcodes 0011011/0111011); always 0 when XLEN=32
- out_illegal  out  1  entry is an illegal instruction

Behaviour:
- Decode is combinational on in_instr. The result plus in_pc and in_instr is captured on accept (in_valid && in_ready). Latency is 1 cycle.
- Field extraction and immediates:
  - U: imm = {instr[31:12], 12'h0}, sign-extended.
  - J: imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - B: imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - I: imm = instr[31:20].
  - S: imm = {instr[31:25], instr[11:7]}.
  - All immediates are sign-extended to XLEN.
  - Unused register/funct fields are 0.
- out_alu_op:
  - B: 000 if funct3=001, else funct3.
  - S, loads, JALR: 000.
  - Otherwise: funct3.
- out_illegal=1 on any of:
  - unknown opcode;
  - JALR with funct3≠000;
  - branch with funct3 010 or 011;
  - load funct3 111, or (XLEN=32 and funct3 ∈ {011, 110});
  - store funct3 ≥100, or (XLEN=32 and funct3=011);
  - OP/OP-32 funct7 not in {0000000, 0100000 (funct3 000 or 101 only), 0000001 if ENABLE_M};
  - OP-IMM shift with nonzero instr[31:25] (XLEN=32) or nonzero instr[31:26] (XLEN=64), except 0100000/010000x with funct3=101;
  - opcodes 0011011/0111011 when XLEN=32;
  - SYSTEM/FENCE opcodes when ENABLE_SYSTEM=0.
- Illegal entries still flow through the pipeline, with out_illegal=1, type 000, all fields 0 except out_pc, out_instr and out_op.
- Buffer state machine (main register M, skid register S):
  - EMPTY: out_valid=0, in_ready=1. On accept → FULL.
  - FULL: out_valid=1.
    - Accept and pop (out_ready): M reloads, stay FULL.
    - Pop only: → EMPTY.
    - Accept without pop: new entry goes to S, in_ready←0 next cycle, → SKID.
  - SKID: in_ready=0. On pop, M←S, in_ready←1, → FULL.
- Ordering is strictly FIFO. Outputs hold stable while out_valid && !out_ready.
- flush: next state is EMPTY and in_ready=1. Flush overrides a same-cycle accept (the input is dropped) and a same-cycle pop.
- Reset (async, reset_n=0):
  - state EMPTY, out_valid=0, in_ready=1;
  - all data outputs 0: out_pc, out_instr, out_op, out_rd, out_rs1, out_rs2, out_funct3, out_funct7, out_alu_op, out_imm, out_instr_type, out_word, out_illegal.
  - Reset mid-transfer loses held entries.

Test Plan:
- ADDI x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, rd=1, rs1=0, imm=5, type=100, alu_op=000, illegal=0.
- LUI x5,0x12345 (0x123452B7) → imm=0x12345000, rd=5, type=001, rs1=rs2=0. BEQ x0,x0,-4 (0xFE000EE3) → imm=0xFFFFFFFC, type=011, rd=0.
- out_ready=0, two back-to-back accepts → in_ready=0 on the following cycle. Raise out_ready → first then second instruction appear in order, and in_ready returns to 1.
- 0x0000007F → out_illegal=1, type=000, out_instr=0x0000007F. MUL x3,x1,x2 (0x022081B3): ENABLE_M=0 → illegal; ENABLE_M=1 → type=110, funct7=0000001, rd=3.
- Flush asserted in SKID state with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed inputs never appear.
- reset_n pulsed low mid-cycle while FULL → out_valid=0 and in_ready=1 immediately. XLEN=64: 0x0000007F-free ADDIW (0x0050009B) → out_word=1, imm=5.
